// File: rtl/pwm_duty_ramp.sv
// pwm_duty_ramp: steps an 8-bit PWM duty toward a programmable target,
// one step per prescaled PWM period, with register write/readback.
module pwm_duty_ramp #(
   parameter int PRESC_W = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        wr_en,
   input  logic [1:0]  wr_addr,
   input  logic [15:0] wr_data,
   input  logic [1:0]  rd_addr,
   output logic [15:0] rd_data,
   input  logic        period_end,
   output logic [7:0]  pwm_duty,
   output logic        busy,
   output logic        done
);
   typedef enum logic [1:0] {IDLE = 2'd0, RAMP_UP = 2'd1, RAMP_DOWN = 2'd2} state_t;
   state_t state, state_n;
   logic [7:0] target, step, stp, duty_n, up_sat, dn_sat;
   logic [PRESC_W-1:0] presc, cnt, cnt_n;
   logic en, imm, tick, done_n;
   logic [8:0] up, dn;
   assign busy = state != IDLE;
   always_comb begin
      tick = period_end && cnt == presc;
      stp = step == 8'd0 ? 8'd1 : step;
      up = {1'b0, pwm_duty} + {1'b0, stp};
      dn = {1'b0, pwm_duty} - {1'b0, stp};
      up_sat = up > {1'b0, target} ? target : up[7:0];
      dn_sat = $signed(dn) < $signed({1'b0, target}) ? target : dn[7:0];
      cnt_n = !en || tick ? '0 : period_end ? cnt + PRESC_W'(1) : cnt;
      state_n = state;
      duty_n = pwm_duty;
      done_n = 1'b0;
      if (!en)
         state_n = IDLE;
      else if (imm) begin
         state_n = IDLE;
         if (period_end) begin
            duty_n = target;
            done_n = pwm_duty != target;
         end
      end else if (pwm_duty == target)
         state_n = IDLE;
      // entering a ramp, or the target moved across the duty: pick direction, no step this cycle
      else if (state == IDLE || (state == RAMP_UP) != (pwm_duty < target))
         state_n = pwm_duty < target ? RAMP_UP : RAMP_DOWN;
      else if (tick) begin
         duty_n = state == RAMP_UP ? up_sat : dn_sat;
         done_n = duty_n == target;
         state_n = done_n ? IDLE : state;
      end
   end
   always_ff @(posedge clk) begin
      if (!rst) begin
         state    <= IDLE;
         pwm_duty <= 8'd0;
         done     <= 1'b0;
         cnt      <= '0;
         target   <= 8'd0;
         step     <= 8'd1;
         presc    <= '0;
         en       <= 1'b0;
         imm      <= 1'b0;
         rd_data  <= 16'd0;
      end else begin
         state    <= state_n;
         pwm_duty <= duty_n;
         done     <= done_n;
         cnt      <= cnt_n;
         target   <= wr_en && wr_addr == 2'd0 ? wr_data[7:0] : target;
         step     <= wr_en && wr_addr == 2'd1 ? wr_data[7:0] : step;
         presc    <= wr_en && wr_addr == 2'd2 ? PRESC_W'(wr_data) : presc;
         en       <= wr_en && wr_addr == 2'd3 ? wr_data[0] : en;
         imm      <= wr_en && wr_addr == 2'd3 ? wr_data[1] : imm;
         rd_data  <= rd_addr == 2'd0 ? {8'd0, target} :
                     rd_addr == 2'd1 ? {8'd0, step} :
                     rd_addr == 2'd2 ? 16'(presc) : {13'd0, state, busy};
      end
   end
endmodule

// File: tb/tb_pwm_duty_ramp.sv
// tb_pwm_duty_ramp: vector table, directed corner sequences and a
// randomized run checked against a behavioural model of the ramp rules.
module tb_pwm_duty_ramp;
   logic clk = 1'b0, rst = 1'b0, wr_en = 1'b0, period_end = 1'b0;
   logic [1:0] wr_addr = 2'd0, rd_addr = 2'd0;
   logic [15:0] wr_data = 16'd0, rd_data;
   logic [7:0] pwm_duty;
   logic busy, done;
   int total = 0, bad = 0;

   pwm_duty_ramp #(.PRESC_W(16)) dut (
      .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .rd_addr(rd_addr), .rd_data(rd_data), .period_end(period_end),
      .pwm_duty(pwm_duty), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       we;
      logic [1:0] wa;
      logic [15:0] wd;
      logic       pe;
      logic [7:0] duty;
      logic       dn;
      logic       bsy;
   } vec_t;
   vec_t tbl[10];

   task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [1:0] a, input logic [15:0] d);
      wr_en = 1'b1; wr_addr = a; wr_data = d;
      cyc();
      wr_en = 1'b0;
   endtask

   task automatic pulse();
      period_end = 1'b1;
      cyc();
      period_end = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b0; wr_en = 1'b0; period_end = 1'b0;
      cyc(); cyc();
      rst = 1'b1;
   endtask

   // behavioural model: plain integers following the ramp rules
   int m_duty, m_tgt, m_step, m_presc, m_cnt, m_dir, m_done, m_rd;
   bit m_en, m_imm;

   task automatic model_reset();
      m_duty = 0; m_tgt = 0; m_step = 1; m_presc = 0; m_cnt = 0;
      m_dir = 0; m_done = 0; m_rd = 0; m_en = 0; m_imm = 0;
   endtask

   task automatic model_step();
      int s, nd;
      bit tk;
      if (!rst) begin
         model_reset();
         return;
      end
      tk = period_end && m_cnt == m_presc;
      m_rd = rd_addr == 0 ? m_tgt : rd_addr == 1 ? m_step : rd_addr == 2 ? m_presc
           : m_dir * 2 + (m_dir != 0 ? 1 : 0);
      m_done = 0;
      if (!m_en) begin
         m_dir = 0;
         m_cnt = 0;
      end else begin
         m_cnt = tk ? 0 : period_end ? (m_cnt + 1) % 65536 : m_cnt;
         if (m_imm) begin
            m_dir = 0;
            if (period_end) begin
               m_done = m_duty != m_tgt;
               m_duty = m_tgt;
            end
         end else if (m_duty == m_tgt) m_dir = 0;
         else if (m_dir == 0 || (m_dir == 1) != (m_duty < m_tgt)) m_dir = m_duty < m_tgt ? 1 : 2;
         else if (tk) begin
            s = m_step == 0 ? 1 : m_step;
            nd = m_dir == 1 ? m_duty + s : m_duty - s;
            if (m_dir == 1 && nd > m_tgt) nd = m_tgt;
            if (m_dir == 2 && nd < m_tgt) nd = m_tgt;
            m_duty = nd;
            if (nd == m_tgt) begin
               m_dir = 0;
               m_done = 1;
            end
         end
      end
      if (wr_en)
         case (wr_addr)
            2'd0: m_tgt = wr_data & 255;
            2'd1: m_step = wr_data & 255;
            2'd2: m_presc = wr_data;
            default: begin m_en = wr_data[0]; m_imm = wr_data[1]; end
         endcase
   endtask

   initial begin
      int dcount;
      tbl[0] = '{1'b1, 2'd1, 16'd16,   1'b0, 8'h00, 1'b0, 1'b0};
      tbl[1] = '{1'b1, 2'd2, 16'd0,    1'b0, 8'h00, 1'b0, 1'b0};
      tbl[2] = '{1'b1, 2'd0, 16'h40,   1'b0, 8'h00, 1'b0, 1'b0};
      tbl[3] = '{1'b1, 2'd3, 16'd1,    1'b0, 8'h00, 1'b0, 1'b0};
      tbl[4] = '{1'b0, 2'd0, 16'd0,    1'b0, 8'h00, 1'b0, 1'b1};
      tbl[5] = '{1'b0, 2'd0, 16'd0,    1'b1, 8'h10, 1'b0, 1'b1};
      tbl[6] = '{1'b0, 2'd0, 16'd0,    1'b1, 8'h20, 1'b0, 1'b1};
      tbl[7] = '{1'b0, 2'd0, 16'd0,    1'b1, 8'h30, 1'b0, 1'b1};
      tbl[8] = '{1'b0, 2'd0, 16'd0,    1'b1, 8'h40, 1'b1, 1'b0};
      tbl[9] = '{1'b0, 2'd0, 16'd0,    1'b0, 8'h40, 1'b0, 1'b0};

      do_reset();
      check("reset duty", 16'(pwm_duty), 16'h0);
      check("reset busy", 16'(busy), 16'h0);
      check("reset done", 16'(done), 16'h0);
      check("reset rd", rd_data, 16'h0);

      for (int i = 0; i < 10; i++) begin
         wr_en = tbl[i].we; wr_addr = tbl[i].wa; wr_data = tbl[i].wd; period_end = tbl[i].pe;
         cyc();
         check($sformatf("tbl%0d duty", i), 16'(pwm_duty), 16'(tbl[i].duty));
         check($sformatf("tbl%0d done", i), 16'(done), 16'(tbl[i].dn));
         check($sformatf("tbl%0d busy", i), 16'(busy), 16'(tbl[i].bsy));
      end
      wr_en = 1'b0; period_end = 1'b0;

      // saturating ramp down from 0x40
      wr(2'd0, 16'h05);
      wr(2'd1, 16'h30);
      pulse();
      check("down1 duty", 16'(pwm_duty), 16'h10);
      check("down1 done", 16'(done), 16'h0);
      pulse();
      check("down2 duty", 16'(pwm_duty), 16'h05);
      check("down2 done", 16'(done), 16'h1);

      // prescale 3: one step per 4 period_end pulses
      do_reset();
      wr(2'd2, 16'd3); wr(2'd1, 16'd1); wr(2'd0, 16'd2); wr(2'd3, 16'd1);
      cyc();
      for (int p = 1; p <= 8; p++) begin
         pulse();
         cyc();
         check($sformatf("presc p%0d", p), 16'(pwm_duty), p < 4 ? 16'd0 : p < 8 ? 16'd1 : 16'd2);
      end

      // no wrap past 0xFF
      do_reset();
      wr(2'd0, 16'hF0); wr(2'd3, 16'd3);
      pulse();
      check("imm F0 duty", 16'(pwm_duty), 16'hF0);
      check("imm F0 done", 16'(done), 16'h1);
      wr(2'd3, 16'd1); wr(2'd1, 16'h80); wr(2'd0, 16'hFF);
      cyc();
      pulse();
      check("sat FF duty", 16'(pwm_duty), 16'hFF);
      check("sat FF done", 16'(done), 16'h1);

      // target rewritten below the duty mid ramp up
      do_reset();
      wr(2'd1, 16'h10); wr(2'd0, 16'h80); wr(2'd3, 16'd1);
      cyc();
      pulse(); pulse();
      check("mid duty", 16'(pwm_duty), 16'h20);
      wr(2'd0, 16'h10);
      rd_addr = 2'd3;
      cyc();
      check("rev busy", 16'(busy), 16'h1);
      cyc();
      check("rev status", rd_data, 16'h5);
      dcount = 0;
      for (int i = 0; i < 10; i++) begin
         period_end = i[0];
         cyc();
         dcount += done;
      end
      period_end = 1'b0;
      check("rev duty", 16'(pwm_duty), 16'h10);
      check("rev done count", 16'(dcount), 16'h1);

      // immediate load, then reset mid ramp
      do_reset();
      wr(2'd0, 16'hA0); wr(2'd3, 16'd3);
      pulse();
      check("imm A0 duty", 16'(pwm_duty), 16'hA0);
      wr(2'd3, 16'd1); wr(2'd0, 16'h10);
      cyc();
      pulse();
      check("pre rst busy", 16'(busy), 16'h1);
      check("pre rst duty", 16'(pwm_duty), 16'h9F);
      rst = 1'b0; wr_en = 1'b1; wr_addr = 2'd0; wr_data = 16'h55;
      cyc();
      wr_en = 1'b0; rst = 1'b1; rd_addr = 2'd0;
      check("rst duty", 16'(pwm_duty), 16'h0);
      check("rst busy", 16'(busy), 16'h0);
      cyc();
      check("rst target", rd_data, 16'h0);
      rd_addr = 2'd1;
      cyc();
      check("rst step", rd_data, 16'h1);

      // randomized run against the model
      do_reset();
      model_reset();
      for (int i = 0; i < 3000; i++) begin
         rst = $urandom_range(0, 199) != 0;
         wr_en = $urandom_range(0, 9) < 3;
         wr_addr = 2'($urandom_range(0, 3));
         wr_data = wr_addr == 2'd2 ? 16'($urandom_range(0, 3)) :
                   wr_addr == 2'd3 ? {14'd0, $urandom_range(0, 4) == 0, $urandom_range(0, 4) != 0} :
                   16'($urandom);
         period_end = $urandom_range(0, 9) < 4;
         rd_addr = 2'($urandom_range(0, 3));
         model_step();
         cyc();
         check("rnd duty", 16'(pwm_duty), 16'(m_duty));
         check("rnd done", 16'(done), 16'(m_done));
         check("rnd busy", 16'(busy), 16'(m_dir != 0));
         check("rnd rd", rd_data, 16'(m_rd));
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
